// File: rtl/cbc_decrypt_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cbc_decrypt_stream                                           |
// | Description : Sequential CBC decryptor for 8-bit bytes made of two 4-bit   |
// |               blocks. One block is decrypted per clock. The CBC state can  |
// |               optionally chain across bytes so a byte stream forms one     |
// |               continuous CBC message.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cbc_decrypt_stream #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       k,
  input  logic [3:0]       iv,
  input  logic             chain,
  input  logic             flush,
  input  logic [7:0]       c_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       p_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BLK0 = 2'd1,
    S_BLK1 = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [7:0]         c_q, c_d;
  logic [3:0]         k_q, k_d;
  logic [3:0]         iv_q, iv_d;
  logic [7:0]         p_out_q, p_out_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [3:0]         chain_reg_q, chain_reg_d;
  logic               chain_vld_q, chain_vld_d;
  logic [3:0]         iv_eff;

  // Block decrypt primitive: rotate right by one, then remove the key.
  function automatic logic [3:0] dec4(input logic [3:0] y, input logic [3:0] key);
    return {y[0], y[3:1]} ^ key;
  endfunction

  // A flush on the accept cycle forces the byte back onto the external iv.
  assign iv_eff = (chain && chain_vld_q && !flush) ? chain_reg_q : iv;

  // Next-state and datapath: accept, decrypt block 0, decrypt block 1, hold for consumer.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    k_d         = k_q;
    iv_d        = iv_q;
    p_out_d     = p_out_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    count_d     = count_q;
    chain_reg_d = chain_reg_q;
    chain_vld_d = chain_vld_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          c_d        = c_in;
          k_d        = k;
          iv_d       = iv_eff;
          in_ready_d = 1'b0;
          state_d    = S_BLK0;
        end
      end
      S_BLK0: begin
        p_out_d[7:4] = dec4(c_q[7:4], k_q) ^ iv_q;
        state_d      = S_BLK1;
      end
      S_BLK1: begin
        p_out_d[3:0] = dec4(c_q[3:0], k_q) ^ c_q[7:4];
        chain_reg_d  = c_q[3:0];
        chain_vld_d  = 1'b1;
        out_valid_d  = 1'b1;
        state_d      = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          count_d     = count_q + C_CNT_ONE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
    // Flush overrides any chain-state update, including the one made in BLK1.
    if (flush) begin
      chain_vld_d = 1'b0;
    end
  end

  // State and output registers; reset discards any byte in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      c_q         <= 8'h00;
      k_q         <= 4'h0;
      iv_q        <= 4'h0;
      p_out_q     <= 8'h00;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      count_q     <= '0;
      chain_reg_q <= 4'h0;
      chain_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      k_q         <= k_d;
      iv_q        <= iv_d;
      p_out_q     <= p_out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      count_q     <= count_d;
      chain_reg_q <= chain_reg_d;
      chain_vld_q <= chain_vld_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign p_out     = p_out_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cbc_decrypt_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cbc_decrypt_stream                                        |
// | Description : Directed self-checking bench for cbc_decrypt_stream.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cbc_decrypt_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] k;
  logic [3:0] iv;
  logic       chain;
  logic       flush;
  logic [7:0] c_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] p_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cbc_decrypt_stream #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .k         (k),
    .iv        (iv),
    .chain     (chain),
    .flush     (flush),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p_out     (p_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  // Offer a byte starting at a negedge; returns at the negedge after the accept edge.
  task automatic send_byte(input logic [7:0] c, output bit ok);
    ok       = 1'b0;
    c_in     = c;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges until out_valid is seen (bounded).
  task automatic wait_out(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || p_out !== 8'h00 || count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b p_out=%h count=%0d, want 0/00/0", out_valid, p_out, count);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    bit ok1, ok2;
    int cyc;
    k = 4'hB; iv = 4'h9; chain = 1'b0;
    send_byte(8'h46, ok1);
    wait_out(cyc, ok2);
    // out_valid visible in the 3rd cycle after the accept cycle (IDLE, BLK0, BLK1, HOLD).
    n_checks++;
    if (!ok1 || !ok2 || cyc != 2) begin
      n_fail++;
      $display("FAIL basic_latency: accepted=%0d seen=%0d cycles=%0d want 1/1/2", ok1, ok2, cyc);
    end
    n_checks++;
    if (p_out !== 8'h0C) begin
      n_fail++;
      $display("FAIL basic_data: got %h want 0c", p_out);
    end
    @(negedge clk);
    n_checks++;
    if (count !== 8'd1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_count: count=%0d out_valid=%b in_ready=%b want 1/0/1", count, out_valid, in_ready);
    end
  endtask

  task automatic test_stream(input logic ch, input logic [7:0] exp2, input string name);
    bit ok1, ok2;
    int cyc;
    pulse_flush();
    chain = ch;
    send_byte(8'h46, ok1);
    wait_out(cyc, ok2);
    n_checks++;
    if (!ok1 || !ok2 || p_out !== 8'h0C) begin
      n_fail++;
      $display("FAIL %s_byte0: got %h (ok=%0d%0d) want 0c", name, p_out, ok1, ok2);
    end
    @(negedge clk);
    send_byte(8'h31, ok1);
    wait_out(cyc, ok2);
    n_checks++;
    if (!ok1 || !ok2 || p_out !== exp2) begin
      n_fail++;
      $display("FAIL %s_byte1: got %h (ok=%0d%0d) want %h", name, p_out, ok1, ok2, exp2);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok1, ok2;
    int cyc;
    logic [7:0] cnt0;
    chain = 1'b0;
    out_ready = 1'b0;
    send_byte(8'h46, ok1);
    wait_out(cyc, ok2);
    cnt0 = count;
    c_in = 8'hFF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (!ok1 || !ok2 || p_out !== 8'h0C || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: p_out=%h out_valid=%b in_ready=%b want 0c/1/0", i, p_out, out_valid, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (count !== cnt0 + 8'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: count=%0d out_valid=%b want %0d/0", count, out_valid, cnt0 + 8'd1);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || count !== cnt0 + 8'd1) begin
      n_fail++;
      $display("FAIL bp_no_extra: out_valid=%b count=%0d want 0/%0d", out_valid, count, cnt0 + 8'd1);
    end
  endtask

  task automatic test_flush();
    bit ok1, ok2;
    int cyc;
    // Flush between bytes.
    chain = 1'b1;
    test_stream(1'b1, 8'h40, "flush_prime");
    pulse_flush();
    send_byte(8'h31, ok1);
    wait_out(cyc, ok2);
    n_checks++;
    if (!ok1 || !ok2 || p_out !== 8'hB0) begin
      n_fail++;
      $display("FAIL flush_between: got %h want b0", p_out);
    end
    @(negedge clk);
    // Chain is valid again (from 0x31, last nibble 1); flush on the accept cycle forces iv.
    flush = 1'b1;
    send_byte(8'h31, ok1);
    flush = 1'b0;
    wait_out(cyc, ok2);
    n_checks++;
    if (!ok1 || !ok2 || p_out !== 8'hB0) begin
      n_fail++;
      $display("FAIL flush_at_accept: got %h want b0", p_out);
    end
    @(negedge clk);
    // Flush during BLK1 must win over the chain update.
    send_byte(8'h46, ok1);
    @(negedge clk);
    flush = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_out(cyc, ok2);
    @(negedge clk);
    send_byte(8'h31, ok1);
    wait_out(cyc, ok2);
    n_checks++;
    if (!ok1 || !ok2 || p_out !== 8'hB0) begin
      n_fail++;
      $display("FAIL flush_in_blk1: got %h want b0", p_out);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bit ok1, ok2;
    int cyc;
    bit all_ok;
    all_ok = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chain = 1'b0;
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h46, ok1);
      wait_out(cyc, ok2);
      if (!ok1 || !ok2) all_ok = 1'b0;
      @(negedge clk);
      if (i == 254) begin
        n_checks++;
        if (count !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_255: count=%0d want 255", count);
        end
      end
    end
    n_checks++;
    if (!all_ok || count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_zero: count=%0d ok=%0d want 0/1", count, all_ok);
    end
  endtask

  task automatic test_reset_midop();
    bit ok1, ok2;
    int cyc;
    chain = 1'b1;
    send_byte(8'h46, ok1);
    wait_out(cyc, ok2);
    @(negedge clk);
    send_byte(8'h46, ok1);
    @(negedge clk);
    // Now in BLK1 with count=1 and chain state valid.
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || p_out !== 8'h00 || count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_midop: out_valid=%b p_out=%h count=%0d want 0/00/0", out_valid, p_out, count);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_discard: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    send_byte(8'h31, ok1);
    wait_out(cyc, ok2);
    n_checks++;
    if (!ok1 || !ok2 || p_out !== 8'hB0) begin
      n_fail++;
      $display("FAIL reset_chain_cleared: got %h want b0", p_out);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; k = 4'hB; iv = 4'h9; chain = 1'b0; flush = 1'b0;
    c_in = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_stream(1'b1, 8'h40, "chained");
    test_stream(1'b0, 8'hB0, "unchained");
    test_backpressure();
    test_flush();
    test_wrap();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
